// File: rtl/tdc_therm_encoder.sv
// tdc_therm_encoder: bubble-corrected thermometer-to-binary encoder for TDC tap snapshots
module tdc_therm_encoder #(
  parameter int LENGTH = 256,
  parameter int CODE_W = $clog2(LENGTH) + 1,
  parameter bit INVERT = 1'b0
) (
  input  logic              clk10m,
  input  logic              rst,
  input  logic              smp_valid,
  input  logic [LENGTH-1:0] smp_taps,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CODE_W-1:0] res_code,
  output logic [2:0]        res_flags,
  output logic [15:0]       drop_cnt
);
  localparam int G = LENGTH / 16;
  logic [LENGTH-1:0] t0, c, c1;
  logic [LENGTH+1:0] e;
  logic v0, v1, v2, cor1, bub1;
  logic [1:0] f2;
  logic [4:0] p2 [G];
  logic [CODE_W-1:0] sum;
  logic sat;
  // virtual taps: below tap 0 reads 1, above the last tap reads 0
  assign e = {1'b0, t0, 1'b1};
  for (genvar i = 0; i < LENGTH; i++) begin : g_maj
    assign c[i] = (e[i] & e[i+1]) | (e[i] & e[i+2]) | (e[i+1] & e[i+2]);
  end
  always_ff @(posedge clk10m) begin
    if (rst) {v0, v1, v2} <= '0;
    else {v0, v1, v2} <= {smp_valid, v0, v1};
  end
  always_ff @(posedge clk10m) begin
    if (smp_valid) t0 <= smp_taps ^ {LENGTH{INVERT}};
    c1 <= c;
    cor1 <= c != t0;
    bub1 <= |(~c[LENGTH-2:0] & c[LENGTH-1:1]);
    f2 <= {bub1, cor1};
    for (int g = 0; g < G; g++) p2[g] <= 5'($countones(c1[g*16 +: 16]));
  end
  always_comb begin
    sum = '0;
    for (int g = 0; g < G; g++) sum = sum + CODE_W'(p2[g]);
  end
  assign sat = (sum == '0) || (sum == CODE_W'(LENGTH));
  // the final sum stage lands directly in the one-entry holding register
  always_ff @(posedge clk10m) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_code <= '0;
      res_flags <= '0;
      drop_cnt <= '0;
    end else if (v2 && (!res_valid || res_ready)) begin
      res_valid <= 1'b1;
      res_code <= sum;
      res_flags <= {sat, f2};
    end else if (v2) drop_cnt <= drop_cnt + 16'(drop_cnt != 16'hFFFF);
    else if (res_ready) res_valid <= 1'b0;
  end
endmodule
